// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues credit-limited requests to instruction memory and
// buffers {instr, pc} for decode. Optional same-cycle bypass under IFETCH_BYPASS_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_arst,
    output logic        o_imemReqValid,
    input  logic        i_imemReqReady,
    output logic [31:0] o_imemReqAddr,
    input  logic        i_imemRspValid,
    input  logic [31:0] i_imemRspData,
    output logic        o_instrValid,
    input  logic        i_instrReady,
    output logic [31:0] o_instr,
    output logic [31:0] o_instrPc,
    input  logic        i_redirectValid,
    input  logic [31:0] i_redirectPc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetchPc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstandingNext;
    logic [CW-1:0] dropCount;
    logic [CW-1:0] fifoCount;
    logic [AW-1:0] fifoWrPtr;
    logic [AW-1:0] fifoRdPtr;
    logic [AW-1:0] pcqWrPtr;
    logic [AW-1:0] pcqRdPtr;
    logic [31:0]   fifoInstr [FIFO_DEPTH];
    logic [31:0]   fifoPc    [FIFO_DEPTH];
    logic [31:0]   pcQueue   [FIFO_DEPTH];

    logic [CW:0]   creditsUsed;
    logic          reqFire;
    logic          fifoEmpty;
    logic          fifoPush;
    logic          fifoPop;
    logic          bypassHit;
    logic [31:0]   rspPc;
    logic          unusedRedirectBits;

    assign unusedRedirectBits = ^i_redirectPc[1:0];

    // Buffered entries plus in-flight requests may never exceed the buffer depth.
    assign creditsUsed    = {1'b0, fifoCount} + {1'b0, outstanding};
    assign o_imemReqValid = !i_arst && (creditsUsed < (CW+1)'(FIFO_DEPTH));
    assign o_imemReqAddr  = fetchPc;
    assign reqFire        = o_imemReqValid && i_imemReqReady;
    assign rspPc          = pcQueue[pcqRdPtr];
    assign fifoEmpty      = (fifoCount == '0);

`ifdef IFETCH_BYPASS_EN
    assign bypassHit = !i_arst && fifoEmpty && (dropCount == '0) && !i_redirectValid && i_imemRspValid;
`else
    assign bypassHit = 1'b0;
`endif

    assign o_instrValid = !i_arst && !i_redirectValid && (!fifoEmpty || bypassHit);
    assign o_instr      = bypassHit ? i_imemRspData : (fifoEmpty ? 32'h0 : fifoInstr[fifoRdPtr]);
    assign o_instrPc    = bypassHit ? rspPc         : (fifoEmpty ? 32'h0 : fifoPc[fifoRdPtr]);

    assign fifoPop  = !fifoEmpty && !i_redirectValid && i_instrReady;
    assign fifoPush = i_imemRspValid && (dropCount == '0) && !i_redirectValid
                      && !(bypassHit && i_instrReady);

    assign outstandingNext = outstanding + CW'(reqFire) - CW'(i_imemRspValid);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            fetchPc     <= RESET_PC;
            outstanding <= '0;
            dropCount   <= '0;
            fifoCount   <= '0;
            fifoWrPtr   <= '0;
            fifoRdPtr   <= '0;
            pcqWrPtr    <= '0;
            pcqRdPtr    <= '0;
        end else begin
            outstanding <= outstandingNext;
            pcqWrPtr    <= pcqWrPtr + AW'(reqFire);
            pcqRdPtr    <= pcqRdPtr + AW'(i_imemRspValid);
            if (i_redirectValid) begin
                fetchPc   <= {i_redirectPc[31:2], 2'b00};
                // Every response still in flight after this edge is stale, including ones
                // already marked for dropping (they are part of outstanding).
                dropCount <= outstandingNext;
                fifoCount <= '0;
                fifoWrPtr <= '0;
                fifoRdPtr <= '0;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + 32'd4;
                end
                if (i_imemRspValid && (dropCount != '0)) begin
                    dropCount <= dropCount - 1'b1;
                end
                fifoCount <= fifoCount + CW'(fifoPush) - CW'(fifoPop);
                fifoWrPtr <= fifoWrPtr + AW'(fifoPush);
                fifoRdPtr <= fifoRdPtr + AW'(fifoPop);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (reqFire && (pcqWrPtr == AW'(gi))) begin
                    pcQueue[gi] <= fetchPc;
                end
                if (fifoPush && (fifoWrPtr == AW'(gi))) begin
                    fifoInstr[gi] <= i_imemRspData;
                    fifoPc[gi]    <= rspPc;
                end
            end
        end
    endgenerate

    rspNeedsRequest: assert property (@(posedge i_clk) disable iff (i_arst)
        i_imemRspValid |-> (outstanding != '0));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a bench-side memory with configurable latency and a
// request-level model (in-flight list with stale flags, expected delivery queue).
module tb_instruction_fetch;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_arst = 1'b1;
    logic        o_imemReqValid;
    logic        i_imemReqReady = 1'b0;
    logic [31:0] o_imemReqAddr;
    logic        i_imemRspValid = 1'b0;
    logic [31:0] i_imemRspData = 32'h0;
    logic        o_instrValid;
    logic        i_instrReady = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_instrPc;
    logic        i_redirectValid = 1'b0;
    logic [31:0] i_redirectPc = 32'h0;

    always #5 i_clk = ~i_clk;

    instruction_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .o_imemReqValid(o_imemReqValid), .i_imemReqReady(i_imemReqReady),
        .o_imemReqAddr(o_imemReqAddr),
        .i_imemRspValid(i_imemRspValid), .i_imemRspData(i_imemRspData),
        .o_instrValid(o_instrValid), .i_instrReady(i_instrReady),
        .o_instr(o_instr), .o_instrPc(o_instrPc),
        .i_redirectValid(i_redirectValid), .i_redirectPc(i_redirectPc)
    );

    typedef struct { logic [31:0] addr; int due; } memReq_t;
    typedef struct { logic [31:0] pc; bit stale; } flight_t;

    memReq_t     memQ[$];
    flight_t     infl[$];
    logic [31:0] mFifo[$];
    logic [31:0] mPc;
    logic [31:0] reqLog[$];
    logic [31:0] dlvLog[$];
    int          reqCyc[$];
    int          dlvCyc[$];
    int          cyc = 0;
    int          memLat = 1;
    bit          memReady = 0;
    bit          decReady = 0;
    bit          redir = 0;
    logic [31:0] redirPc = 32'h0;
    int          passed = 0;
    int          total = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] reqAt(input int i);
        return (reqLog.size() > i) ? reqLog[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dlvAt(input int i);
        return (dlvLog.size() > i) ? dlvLog[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clearLogs();
        reqLog.delete(); dlvLog.delete(); reqCyc.delete(); dlvCyc.delete();
    endtask

    task automatic doReset();
        i_arst = 1'b1;
        i_imemReqReady = 1'b0; i_imemRspValid = 1'b0; i_imemRspData = 32'h0;
        i_instrReady = 1'b0; i_redirectValid = 1'b0; i_redirectPc = 32'h0;
        memQ.delete(); infl.delete(); mFifo.delete();
        mPc = RST_PC; redir = 0;
        repeat (2) @(negedge i_clk);
        #1;
        check("rstReqValid", o_imemReqValid, 0);
        check("rstInstrValid", o_instrValid, 0);
        check("rstInstr", o_instr, 32'h0);
        check("rstInstrPc", o_instrPc, 32'h0);
        #1 i_arst = 1'b0;
        clearLogs();
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step();
        bit          rsp, fire, expReqValid, expValid, bypassHit;
        logic [31:0] expPc;
        flight_t     r;
        r = '{pc: 32'h0, stale: 1'b0};
        expPc = 32'h0;
        @(negedge i_clk);
        rsp = (memQ.size() > 0) && (memQ[0].due <= cyc);
        i_imemRspValid  = rsp;
        i_imemRspData   = rsp ? memWord(memQ[0].addr) : 32'h0;
        i_imemReqReady  = memReady;
        i_instrReady    = decReady;
        i_redirectValid = redir;
        i_redirectPc    = redirPc;
        #1;
        expReqValid = (mFifo.size() + infl.size()) < DEPTH;
        check("reqValid", o_imemReqValid, expReqValid);
        if (expReqValid) check("reqAddr", o_imemReqAddr, mPc);
        bypassHit = 0;
`ifdef IFETCH_BYPASS_EN
        bypassHit = (mFifo.size() == 0) && rsp && !redir && (infl.size() > 0) && !infl[0].stale;
`endif
        expValid = !redir && ((mFifo.size() > 0) || bypassHit);
        check("instrValid", o_instrValid, expValid);
        if (expValid) begin
            expPc = (mFifo.size() > 0) ? mFifo[0] : infl[0].pc;
            check("instrPc", o_instrPc, expPc);
            check("instr", o_instr, memWord(expPc));
        end

        fire = o_imemReqValid && memReady;
        if (rsp) void'(memQ.pop_front());
        if (fire) begin
            reqLog.push_back(o_imemReqAddr);
            reqCyc.push_back(cyc);
            memQ.push_back(memReq_t'{addr: o_imemReqAddr, due: cyc + memLat});
        end
        if (expValid && decReady) begin
            dlvLog.push_back(expPc);
            dlvCyc.push_back(cyc);
            $display("cycle %0d: deliver pc=%h instr=%h", cyc, o_instrPc, o_instr);
        end

        if (rsp && (infl.size() > 0)) r = infl.pop_front();
        if (redir) begin
            mFifo.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            if (fire) infl.push_back(flight_t'{pc: mPc, stale: 1'b1});
            mPc = redirPc & ~32'h3;
        end else begin
            if (expValid && decReady && !bypassHit) void'(mFifo.pop_front());
            if (rsp && !r.stale && !(bypassHit && decReady)) mFifo.push_back(r.pc);
            if (fire) begin
                infl.push_back(flight_t'{pc: mPc, stale: 1'b0});
                mPc = mPc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        // Free run, single-cycle memory.
        doReset();
        memLat = 1; memReady = 1; decReady = 1;
        repeat (8) step();
        check("t1Req0", reqAt(0), 32'h0);
        check("t1Req1", reqAt(1), 32'h4);
        check("t1Req2", reqAt(2), 32'h8);
        check("t1Dlv0", dlvAt(0), 32'h0);
        check("t1Dlv1", dlvAt(1), 32'h4);
        check("t1Dlv2", dlvAt(2), 32'h8);
        check("t1Rate", dlvCyc.size() > 2 ? 32'(dlvCyc[2] - dlvCyc[0]) : 32'hFFFF, 32'd2);
`ifdef IFETCH_BYPASS_EN
        check("t1Latency", (dlvCyc.size() > 0 && reqCyc.size() > 0) ? 32'(dlvCyc[0] - reqCyc[0]) : 32'hFFFF, 32'd1);
`else
        check("t1Latency", (dlvCyc.size() > 0 && reqCyc.size() > 0) ? 32'(dlvCyc[0] - reqCyc[0]) : 32'hFFFF, 32'd2);
`endif

        // Decode stalled: the buffer fills and credits run out.
        doReset();
        memLat = 1; memReady = 1; decReady = 0;
        repeat (8) step();
        check("t2ReqCount", 32'(reqLog.size()), 32'd4);
        check("t2ReqValidLow", o_imemReqValid, 0);
        check("t2NoDeliver", 32'(dlvLog.size()), 32'd0);
        decReady = 1;
        clearLogs();
        repeat (8) step();
        check("t2Dlv0", dlvAt(0), 32'h0);
        check("t2Dlv1", dlvAt(1), 32'h4);
        check("t2Dlv2", dlvAt(2), 32'h8);
        check("t2Dlv3", dlvAt(3), 32'hC);
        check("t2Resume", reqAt(0), 32'h10);

        // Slow memory, redirect with two requests in flight.
        doReset();
        memLat = 3; memReady = 1; decReady = 1;
        repeat (2) step();
        memReady = 0; redir = 1; redirPc = 32'h103;
        step();
        redir = 0; memReady = 1;
        clearLogs();
        repeat (10) step();
        check("t3Req0", reqAt(0), 32'h100);
        check("t3Dlv0", dlvAt(0), 32'h100);

        // Redirect coinciding with a response and a request fire.
        doReset();
        memLat = 1; memReady = 1; decReady = 1;
        step();
        redir = 1; redirPc = 32'h200;
        step();
        redir = 0;
        clearLogs();
        repeat (6) step();
        check("t4Req0", reqAt(0), 32'h200);
        check("t4Dlv0", dlvAt(0), 32'h200);
        check("t4Dlv1", dlvAt(1), 32'h204);

        // Fetch PC wraps around the top of the address space.
        doReset();
        memLat = 1; memReady = 0; decReady = 1;
        redir = 1; redirPc = 32'hFFFF_FFF8;
        step();
        redir = 0; memReady = 1;
        clearLogs();
        repeat (6) step();
        check("t5Req0", reqAt(0), 32'hFFFF_FFF8);
        check("t5Req1", reqAt(1), 32'hFFFF_FFFC);
        check("t5Req2", reqAt(2), 32'h0000_0000);

        // Asynchronous reset with three buffered entries.
        doReset();
        memLat = 1; memReady = 1; decReady = 0;
        repeat (3) step();
        memReady = 0;
        repeat (2) step();
        check("t6PreInstrValid", o_instrValid, 1);
        check("t6PreReqValid", o_imemReqValid, 1);
        #2 i_arst = 1'b1;
        #1;
        check("t6AsyncInstrValid", o_instrValid, 0);
        check("t6AsyncReqValid", o_imemReqValid, 0);
        doReset();
        memReady = 1; decReady = 1;
        repeat (4) step();
        check("t6Restart", reqAt(0), RST_PC);
        check("t6RestartDlv", dlvAt(0), RST_PC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
